// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction memory and decode handshake bundle for the fetch unit
interface instruction_fetch_unit_if;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_read_data;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  modport master (
    output imem_read, imem_address, instr_out, pc_out, instr_valid, halted,
    input  imem_read_data, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_read, imem_address, instr_out, pc_out, instr_valid, halted,
    output imem_read_data, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, instruction memory read strobe and one-entry output register
// Optional FETCH_COUNT_EN adds the fetch_count handshake counter port.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] PC_STEP    = 32'd4,
  parameter logic [31:0] ADDR_LIMIT = 32'd32
) (
  input  logic clk,
  input  logic reset,
`ifdef FETCH_COUNT_EN
  output logic [31:0] fetch_count,
`endif
  instruction_fetch_unit_if.master bus
);

  typedef enum logic [0:0] {FETCH, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        read_en;
  logic        load;

  assign load = !valid_q || bus.instr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0;
      pc_out_q <= 32'h0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    read_en  = 1'b0;
    // Redirect squashes the pending word even if decode accepts it this cycle.
    if (bus.redirect_valid) begin
      pc_d     = bus.redirect_pc & ~32'h3;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      state_d  = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (load) begin
            if (pc_q < ADDR_LIMIT) begin
              read_en  = 1'b1;
              instr_d  = bus.imem_read_data;
              pc_out_d = pc_q;
              valid_d  = 1'b1;
              pc_d     = pc_q + PC_STEP;
            end else begin
              state_d  = HALT;
              halted_d = 1'b1;
              valid_d  = 1'b0;
            end
          end
        end
        HALT: begin
          if (valid_q && bus.instr_ready) begin
            valid_d = 1'b0;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign bus.imem_read    = read_en && !reset;
  assign bus.imem_address = pc_q;
  assign bus.instr_out    = instr_q;
  assign bus.pc_out       = pc_out_q;
  assign bus.instr_valid  = valid_q;
  assign bus.halted       = halted_q;

`ifdef FETCH_COUNT_EN
  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (valid_q && bus.instr_ready && !bus.redirect_valid) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 32'h0;
    end else begin
      count_q <= count_d;
    end
  end

  assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [63:0] sb_q[$];
  logic [31:0] mem [8];

`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC   (32'h0),
    .PC_STEP    (32'd4),
    .ADDR_LIMIT (32'd32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef FETCH_COUNT_EN
    .fetch_count (fetch_count),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_read_data = mem[bus.imem_address[4:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    sb_q.push_back({instr, pc});
  endtask

  // Monitor: every accepted, non-squashed instruction must match the next expected entry.
  always @(negedge clk) begin
    if (!reset && bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", bus.pc_out, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        chk("sb_instr", bus.instr_out, e[63:32]);
        chk("sb_pc", bus.pc_out, e[31:0]);
      end
    end
  end

  initial begin
    mem[0] = 32'h20C30005; mem[1] = 32'h00661822; mem[2] = 32'h20410006; mem[3] = 32'h20410003;
    mem[4] = 32'h20410001; mem[5] = 32'h8C220014; mem[6] = 32'hAC220018; mem[7] = 32'h1000FFFF;
    reset = 1'b1;
    bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;

    tick();
    chk("rst_imem_read", {31'b0, bus.imem_read}, 32'd0);
    chk("rst_imem_addr", bus.imem_address, 32'h0);
    chk("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("rst_halted", {31'b0, bus.halted}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("first_read", {31'b0, bus.imem_read}, 32'd1);
    chk("first_addr", bus.imem_address, 32'h0);
    chk("first_valid_early", {31'b0, bus.instr_valid}, 32'd0);
    for (int i = 0; i < 8; i++) push(mem[i], 32'(i * 4));

    tick();
    chk("first_valid", {31'b0, bus.instr_valid}, 32'd1);
    tick();
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_instr", bus.instr_out, 32'h00661822);
      chk("stall_pc", bus.pc_out, 32'd4);
      chk("stall_valid", {31'b0, bus.instr_valid}, 32'd1);
      chk("stall_read", {31'b0, bus.imem_read}, 32'd0);
      chk("stall_addr", bus.imem_address, 32'd8);
      tick();
    end
    bus.instr_ready = 1'b1;
    tick();
    chk("resume_instr", bus.instr_out, 32'h20410006);
    chk("resume_pc", bus.pc_out, 32'd8);

    for (int i = 0; i < 40 && !bus.halted; i++) tick();
    #1;
    chk("halt_flag", {31'b0, bus.halted}, 32'd1);
    chk("halt_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("halt_read", {31'b0, bus.imem_read}, 32'd0);
    chk("halt_addr", bus.imem_address, 32'd32);
    tick();
    tick();
    chk("halt_hold", {31'b0, bus.halted}, 32'd1);
    chk("halt_hold_addr", bus.imem_address, 32'd32);

    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0;
    #1;
    chk("redir_read", {31'b0, bus.imem_read}, 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("redir_halted", {31'b0, bus.halted}, 32'd0);
    chk("redir_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("redir_addr", bus.imem_address, 32'h0);
    chk("redir_fetch", {31'b0, bus.imem_read}, 32'd1);
    push(32'h20C30005, 32'd0);
    tick();
    chk("redir_instr", bus.instr_out, 32'h20C30005);
    tick();
    chk("squash_pc", bus.pc_out, 32'd4);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000000E;
    #1;
    chk("squash_read", {31'b0, bus.imem_read}, 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("squash_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("squash_addr", bus.imem_address, 32'h0000000C);
    push(32'h20410003, 32'd12);
    tick();
    chk("target_instr", bus.instr_out, 32'h20410003);
    chk("target_pc", bus.pc_out, 32'd12);
    tick();
    bus.instr_ready = 1'b0;
    #1;
    chk("pre_reset_valid", {31'b0, bus.instr_valid}, 32'd1);
`ifdef FETCH_COUNT_EN
    chk("fetch_count", fetch_count, 32'd10);
`endif

    reset = 1'b1;
    tick();
    chk("mid_rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("mid_rst_halted", {31'b0, bus.halted}, 32'd0);
    chk("mid_rst_addr", bus.imem_address, 32'h0);
    chk("mid_rst_read", {31'b0, bus.imem_read}, 32'd0);
`ifdef FETCH_COUNT_EN
    chk("fetch_count_rst", fetch_count, 32'd0);
`endif
    reset = 1'b0;
    tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
